// File: rtl/prime_factorizer.sv
// prime_factorizer: decomposes unsigned integers into ascending prime factors
// by trial division, using a 1-bit/cycle restoring divider (WIDTH cycles per trial).
// Each factor leaves on a valid/ready stream; out_last marks the final factor.
// Optional build macro PRIME_FACTOR_MULT_EN: repeated factors are merged into one
// beat and the multiplicity is reported on out_exp.
module prime_factorizer #(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_number,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_factor,
    output logic                    out_last
`ifdef PRIME_FACTOR_MULT_EN
    ,
    output logic [$clog2(WIDTH):0]  out_exp
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam int EW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, DIV, CHECK, EMIT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] n_rem_q, n_rem_d;     // value still to be factored
    logic [WIDTH-1:0] d_q, d_d;             // current trial divisor
    logic [WIDTH-1:0] rem_q, rem_d;         // divider partial remainder
    logic [WIDTH-1:0] quot_q, quot_d;       // dividend shifting out / quotient shifting in
    logic [CW-1:0]    cnt_q, cnt_d;         // divider step counter
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic [WIDTH-1:0] out_factor_q, out_factor_d;

    logic [WIDTH:0]   rem_sh;               // remainder shifted left with next dividend bit
    logic [WIDTH:0]   rem_sub;              // trial subtraction; MSB is the borrow
    logic [WIDTH-1:0] d_nxt;                // next odd candidate (2 -> 3 -> 5 ...)

`ifdef PRIME_FACTOR_MULT_EN
    logic [EW-1:0]    exp_q, exp_d;         // multiplicity of d accumulated so far
    logic [EW-1:0]    out_exp_q, out_exp_d;
    logic [EW-1:0]    exp_inc;
`endif

    // Next-state, divider datapath and output-beat computation
    always_comb begin
        state_d      = state_q;
        n_rem_d      = n_rem_q;
        d_d          = d_q;
        rem_d        = rem_q;
        quot_d       = quot_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_factor_d = out_factor_q;
`ifdef PRIME_FACTOR_MULT_EN
        exp_d        = exp_q;
        out_exp_d    = out_exp_q;
        exp_inc      = exp_q + EW'(1);
`endif
        rem_sh  = {rem_q, quot_q[WIDTH-1]};
        rem_sub = rem_sh - {1'b0, d_q};
        d_nxt   = (d_q == WIDTH'(2)) ? WIDTH'(3) : d_q + WIDTH'(2);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    n_rem_d = in_number;
                    d_d     = WIDTH'(2);
`ifdef PRIME_FACTOR_MULT_EN
                    exp_d   = '0;
`endif
                    if (in_number <= WIDTH'(1)) begin
                        // 0 and 1 are passed through as a single final beat
                        state_d      = EMIT;
                        out_valid_d  = 1'b1;
                        out_factor_d = in_number;
                        out_last_d   = 1'b1;
`ifdef PRIME_FACTOR_MULT_EN
                        out_exp_d    = EW'(1);
`endif
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                // Restoring step: keep the subtraction only when it does not borrow
                if (!rem_sub[WIDTH]) begin
                    rem_d  = rem_sub[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d  = rem_sh[WIDTH-1:0];
                    quot_d = {quot_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) state_d = CHECK;
            end
            CHECK: begin
                // quot_q = n_rem / d, rem_q = n_rem % d; q < d stands in for d*d > n_rem
`ifdef PRIME_FACTOR_MULT_EN
                if (rem_q == '0) begin
                    n_rem_d = quot_q;
                    exp_d   = exp_inc;
                    if (quot_q == WIDTH'(1)) begin
                        state_d      = EMIT;
                        out_valid_d  = 1'b1;
                        out_factor_d = d_q;
                        out_exp_d    = exp_inc;
                        out_last_d   = 1'b1;
                        exp_d        = '0;
                    end else begin
                        state_d = DIV;
                    end
                end else if (exp_q != '0) begin
                    // d no longer divides: flush the merged beat, then move on
                    state_d      = EMIT;
                    out_valid_d  = 1'b1;
                    out_factor_d = d_q;
                    out_exp_d    = exp_q;
                    out_last_d   = (n_rem_q == WIDTH'(1));
                    exp_d        = '0;
                    d_d          = d_nxt;
                end else if (quot_q < d_q) begin
                    state_d      = EMIT;
                    out_valid_d  = 1'b1;
                    out_factor_d = n_rem_q;
                    out_exp_d    = EW'(1);
                    out_last_d   = 1'b1;
                end else begin
                    d_d     = d_nxt;
                    state_d = DIV;
                end
`else
                if (rem_q == '0) begin
                    // keep d: it may divide the quotient again
                    state_d      = EMIT;
                    out_valid_d  = 1'b1;
                    out_factor_d = d_q;
                    out_last_d   = (quot_q == WIDTH'(1));
                    n_rem_d      = quot_q;
                end else if (quot_q < d_q) begin
                    state_d      = EMIT;
                    out_valid_d  = 1'b1;
                    out_factor_d = n_rem_q;
                    out_last_d   = 1'b1;
                end else begin
                    d_d     = d_nxt;
                    state_d = DIV;
                end
`endif
            end
            EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = out_last_q ? IDLE : DIV;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every entry into DIV starts a fresh division of the (possibly updated) n_rem
        if (state_d == DIV && state_q != DIV) begin
            rem_d  = '0;
            quot_d = n_rem_d;
            cnt_d  = '0;
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            n_rem_q      <= '0;
            d_q          <= '0;
            rem_q        <= '0;
            quot_q       <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_factor_q <= '0;
`ifdef PRIME_FACTOR_MULT_EN
            exp_q        <= '0;
            out_exp_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            n_rem_q      <= n_rem_d;
            d_q          <= d_d;
            rem_q        <= rem_d;
            quot_q       <= quot_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_factor_q <= out_factor_d;
`ifdef PRIME_FACTOR_MULT_EN
            exp_q        <= exp_d;
            out_exp_q    <= out_exp_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign out_factor = out_factor_q;
`ifdef PRIME_FACTOR_MULT_EN
    assign out_exp    = out_exp_q;
`endif

endmodule
